slt_iter: RTL and testbench
===========================

# slt_iter

Iterative, parametrised set-compare unit for the RV32 R/I-format datapath. It generalises the combinational signed set-less-than into a multi-cycle comparator with four modes: SLT, SLTU, SEQ and SNE. It walks the operands CHUNK bits per cycle from the MSB down, with optional early exit. The unit sits between the register-read stage and writeback, behind a valid/ready handshake on both sides, and returns a zero-extended N-bit result.

## Interface
- N, 32: operand and result width; must be ≥ 2.
- CHUNK, 8: bits compared per cycle; must divide N. S = N/CHUNK steps.
- EARLY_EXIT, 0: 1 = finish as soon as the outcome is decided; 0 = fixed latency.

- clk  in  1  rising-edge clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  unit can accept a new operation.
- op  in  2  00 SLT (signed), 01 SLTU, 10 SEQ, 11 SNE.
- X  in  N  first operand.
- Y  in  N  second operand.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- result  out  N  {N-1 zeros, flag}.
- busy  out  1  state ≠ IDLE.

## Operation
- **States**
  - IDLE: in_ready=1.
  - BUSY: stepping.
  - DONE: out_valid=1.
- **IDLE → BUSY** on the edge where in_valid && in_ready.
  - Latch X, Y, op.
  - For SLT, latch X and Y with their MSBs inverted. This maps signed order onto unsigned order.
  - Clear decided, lt, neq. Load step=S-1.
- **BUSY**: each edge compares chunk [step*CHUNK +: CHUNK] of both latched operands. If decided=0 and the chunks differ:
  - lt := (Xc < Yc) unsigned.
  - neq := 1.
  - decided := 1.
- **BUSY exit**
  - After the chunk with step=0 is processed, go to DONE.
  - If EARLY_EXIT=1, also go to DONE on the edge where decided is first set.
  - Otherwise step decrements.
- **Result flag**
  - SLT, SLTU: lt.
  - SEQ: ~neq.
  - SNE: neq.
  - result is registered on entry to DONE.
- **DONE → IDLE** on the edge where out_ready=1. A new operation cannot be accepted in that same cycle, because in_ready=0 in DONE.
- **Ignored inputs**
  - in_valid is ignored in BUSY and DONE.
  - X, Y and op may change freely after acceptance.
- **Signed boundaries**
  - 0x80000000 < 0x7FFFFFFF under SLT.
  - 0x80000000 > 0x7FFFFFFF under SLTU.
- **Reset** (rstn low at any edge, including mid-BUSY or DONE):
  - state = IDLE; out_valid = 0; result = 0; busy = 0.
  - Internal regs cleared. No partial result is ever emitted.
  - in_ready is forced 0 while rstn=0 and is 1 from the first cycle after release.

## Timing
- Let E0 be the accept edge.
- **EARLY_EXIT=0**
  - Chunks are processed on edges E1..ES.
  - out_valid rises after ES.
  - Latency S+1 edges, independent of data.
- **EARLY_EXIT=1**
  - out_valid rises after edge Ek, where k is the index (1-based from MSB) of the first differing chunk.
  - Equal operands take S+1 edges.
  - Minimum latency is 2 edges.
- **Result hold**: result and out_valid are held stable while out_ready=0, indefinitely.
- **Throughput**: back-to-back with out_ready=1 and in_valid=1, one operation per S+2 cycles (EARLY_EXIT=0).
- **Combinational paths**: in_ready and busy are decoded from state only. There is no combinational path from any input to any output.

## Test plan
Unless noted: N=32, CHUNK=8, EARLY_EXIT=0.

- **Signed vs unsigned**: SLT X=0xFFFFFFFF, Y=0x00000001 → out_valid exactly 5 edges after accept, result=1. Same operands with SLTU → result=0.
- **Sign boundary**: SLT X=0x80000000, Y=0x7FFFFFFF → result=1. SLTU → 0. SLT X=Y=0x80000000 → 0.
- **Equality**
  - SEQ X=Y=0x12345678 → 1; SNE → 0.
  - SEQ X=0x12345679, Y=0x12345678 (LSB chunk only differs) → 0; SNE → 1.
- **Early exit** (EARLY_EXIT=1):
  - SLTU X=0x01000000, Y=0x02000000 → out_valid 2 edges after accept, result=1.
  - X=Y=0 → 5 edges.
  - Also run with CHUNK=4 and N=16 to cover other parametrisations.
- **Backpressure**: hold out_ready=0 for 6 cycles after out_valid while toggling in_valid/X/Y/op.
  - result stays constant and in_ready=0.
  - Releasing out_ready gives IDLE next cycle; the next operation is accepted with correct latency.
- **Reset mid-operation**: assert rstn=0 for one edge during E2 of an SLT.
  - Next cycle: out_valid=0, result=0, busy=0.
  - in_ready=1 after release.
  - A fresh SLTU 3<5 returns 1 with no stale data.

Source files
------------

// File: rtl/slt_iter.sv
// slt_iter: iterative set-compare unit (SLT / SLTU / SEQ / SNE), CHUNK bits per cycle, MSB first.
// Latency: S+1 edges from accept to out_valid (EARLY_EXIT=0); k+1 edges when chunk k is the first difference (EARLY_EXIT=1).
// Backpressure: in_ready only in IDLE; result/out_valid held in DONE until out_ready, in_valid ignored meanwhile.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (op, X, Y sampled on accept)
//   out_valid/out_ready   result handshake; result = {N-1 zeros, flag}
//   busy                  unit is not idle
module slt_iter #(
  parameter int N          = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         busy
);

  localparam int S  = N / CHUNK;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam logic [SW-1:0] STEP_TOP = SW'(S - 1);
  localparam logic [N-1:0]  MSB_MASK = {1'b1, {(N-1){1'b0}}};

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SNE  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]     op_q, op_d;
  logic [SW-1:0]  step_q, step_d;
  logic           decided_q, decided_d;
  logic           lt_q, lt_d;
  logic           neq_q, neq_d;
  logic           flag_q, flag_d;
  // Goes high on the first edge with rstn released; keeps in_ready low during reset.
  logic           live_q;

  // Chunk views of the latched operands, index 0 = least significant chunk.
  logic [CHUNK-1:0] x_chunks [S];
  logic [CHUNK-1:0] y_chunks [S];
  logic [CHUNK-1:0] xc, yc;
  logic             hit;

  for (genvar g = 0; g < S; g++) begin : g_chunk
    assign x_chunks[g] = x_q[g*CHUNK +: CHUNK];
    assign y_chunks[g] = y_q[g*CHUNK +: CHUNK];
  end

  assign xc  = x_chunks[step_q];
  assign yc  = y_chunks[step_q];
  assign hit = !decided_q && (xc != yc);

  assign in_ready  = (state_q == ST_IDLE) && live_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = {{(N-1){1'b0}}, flag_q};

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    op_d      = op_q;
    step_d    = step_q;
    decided_d = decided_q;
    lt_d      = lt_q;
    neq_d     = neq_q;
    flag_d    = flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && live_q) begin
          state_d   = ST_BUSY;
          // Flipping both sign bits turns signed order into unsigned order.
          x_d       = (op == OP_SLT) ? (X ^ MSB_MASK) : X;
          y_d       = (op == OP_SLT) ? (Y ^ MSB_MASK) : Y;
          op_d      = op;
          step_d    = STEP_TOP;
          decided_d = 1'b0;
          lt_d      = 1'b0;
          neq_d     = 1'b0;
        end
      end
      ST_BUSY: begin
        // The first differing chunk from the MSB decides the whole comparison.
        if (hit) begin
          lt_d      = (xc < yc);
          neq_d     = 1'b1;
          decided_d = 1'b1;
        end
        if (step_q == '0 || (EARLY_EXIT != 0 && hit)) begin
          state_d = ST_DONE;
          unique case (op_d)
            OP_SLT, OP_SLTU: flag_d = lt_d;
            OP_SEQ:          flag_d = !neq_d;
            OP_SNE:          flag_d = neq_d;
            default:         flag_d = 1'b0;
          endcase
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= '0;
      step_q    <= '0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
      neq_q     <= 1'b0;
      flag_q    <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      op_q      <= op_d;
      step_q    <= step_d;
      decided_q <= decided_d;
      lt_q      <= lt_d;
      neq_q     <= neq_d;
      flag_q    <= flag_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slt_iter.sv
// tb_slt_iter: drives three slt_iter instances (32/8 fixed latency, 32/8 early exit, 16/4 early exit).
// Latency: measured in rising edges from the accept edge to the first cycle out_valid is seen.
// Backpressure: out_ready held low in one scenario while inputs are toggled.
module tb_slt_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  in_valid = 3'b000;
  logic        out_ready = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic [2:0]  in_ready, out_valid, busy;
  logic [31:0] res_a, res_b;
  logic [15:0] res_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          sel;
    logic [1:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic        f;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  slt_iter #(.N(32), .CHUNK(8), .EARLY_EXIT(0)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op),
    .X(X), .Y(Y), .out_valid(out_valid[0]), .out_ready(out_ready), .result(res_a), .busy(busy[0]));

  slt_iter #(.N(32), .CHUNK(8), .EARLY_EXIT(1)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op),
    .X(X), .Y(Y), .out_valid(out_valid[1]), .out_ready(out_ready), .result(res_b), .busy(busy[1]));

  slt_iter #(.N(16), .CHUNK(4), .EARLY_EXIT(1)) u_c (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .op(op),
    .X(X[15:0]), .Y(Y[15:0]), .out_valid(out_valid[2]), .out_ready(out_ready), .result(res_c), .busy(busy[2]));

  function automatic logic [31:0] get_res(input int sel);
    if (sel == 0) return res_a;
    if (sel == 1) return res_b;
    return {16'h0, res_c};
  endfunction

  function automatic int width_of(input int sel);  return (sel == 2) ? 16 : 32; endfunction
  function automatic int chunk_of(input int sel);  return (sel == 2) ? 4 : 8;   endfunction
  function automatic bit early_of(input int sel);  return (sel != 0);          endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  // Reference flag from plain arithmetic on n-bit values.
  function automatic logic model_flag(input logic [1:0] o, input logic [31:0] xi, input logic [31:0] yi, input int n);
    logic [31:0] x, y;
    x = xi & mask_of(n);
    y = yi & mask_of(n);
    case (o)
      2'd0:    return ($signed(x << (32 - n)) < $signed(y << (32 - n)));
      2'd1:    return (x < y);
      2'd2:    return (x == y);
      default: return (x != y);
    endcase
  endfunction

  // Reference latency: S+1, or (index of first differing chunk from the MSB)+1 with early exit.
  function automatic int model_lat(input logic [31:0] xi, input logic [31:0] yi, input int n, input int c, input bit ee);
    int s;
    logic [31:0] x, y, cm;
    s  = n / c;
    x  = xi & mask_of(n);
    y  = yi & mask_of(n);
    cm = mask_of(c);
    if (!ee) return s + 1;
    for (int i = 0; i < s; i++) begin
      if (((x >> ((s - 1 - i) * c)) & cm) != ((y >> ((s - 1 - i) * c)) & cm)) return i + 2;
    end
    return s + 1;
  endfunction

  // Presents one operation and waits (bounded) for its result.
  task automatic issue(input int sel, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output bit to);
    int w;
    to  = 1'b0;
    lat = 0;
    res = '0;
    @(negedge clk);
    w = 0;
    while (!in_ready[sel] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready[sel]) begin
      to = 1'b1;
      return;
    end
    op = o; X = x; Y = y;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    op = 2'($urandom); X = $urandom; Y = $urandom;
    lat = 1;
    while (!out_valid[sel] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[sel]) to = 1'b1;
    res = get_res(sel);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 000", in_ready); end
    n_checks++;
    if (out_valid !== 3'b000 || busy !== 3'b000) begin
      n_fail++; $display("FAIL reset_out_busy: out_valid=%b busy=%b want 000/000", out_valid, busy);
    end
    n_checks++;
    if (res_a !== 32'h0 || res_c !== 16'h0) begin
      n_fail++; $display("FAIL reset_result: a=%h c=%h want 0", res_a, res_c);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 3'b111) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 111", in_ready); end
  endtask

  task automatic test_signed_compare();
    vec_t v[5];
    int lat; logic [31:0] res; bit to;
    v[0] = '{0, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5};
    v[1] = '{0, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5};
    v[2] = '{0, 2'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 5};
    v[3] = '{0, 2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 5};
    v[4] = '{0, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 5};
    foreach (v[i]) begin
      issue(v[i].sel, v[i].o, v[i].x, v[i].y, lat, res, to);
      n_checks++;
      if (to || res !== {31'h0, v[i].f}) begin
        n_fail++; $display("FAIL signed[%0d]: result=%h want %h timeout=%0d", i, res, {31'h0, v[i].f}, to);
      end
      n_checks++;
      if (lat !== v[i].lat) begin n_fail++; $display("FAIL signed_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_equality();
    vec_t v[5];
    int lat; logic [31:0] res; bit to;
    v[0] = '{0, 2'd2, 32'h1234_5678, 32'h1234_5678, 1'b1, 5};
    v[1] = '{0, 2'd3, 32'h1234_5678, 32'h1234_5678, 1'b0, 5};
    v[2] = '{0, 2'd2, 32'h1234_5679, 32'h1234_5678, 1'b0, 5};
    v[3] = '{0, 2'd3, 32'h1234_5679, 32'h1234_5678, 1'b1, 5};
    v[4] = '{1, 2'd3, 32'h1234_5679, 32'h1234_5678, 1'b1, 5};
    foreach (v[i]) begin
      issue(v[i].sel, v[i].o, v[i].x, v[i].y, lat, res, to);
      n_checks++;
      if (to || res !== {31'h0, v[i].f}) begin
        n_fail++; $display("FAIL equality[%0d]: result=%h want %h timeout=%0d", i, res, {31'h0, v[i].f}, to);
      end
      n_checks++;
      if (lat !== v[i].lat) begin n_fail++; $display("FAIL equality_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_early_exit();
    vec_t v[5];
    int lat; logic [31:0] res; bit to;
    v[0] = '{1, 2'd1, 32'h0100_0000, 32'h0200_0000, 1'b1, 2};
    v[1] = '{1, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b1, 5};
    v[2] = '{2, 2'd1, 32'h0000_0100, 32'h0000_0200, 1'b1, 3};
    v[3] = '{2, 2'd0, 32'h0000_8000, 32'h0000_7FFF, 1'b1, 2};
    v[4] = '{2, 2'd2, 32'h0000_ABCD, 32'h0000_ABCD, 1'b1, 5};
    foreach (v[i]) begin
      issue(v[i].sel, v[i].o, v[i].x, v[i].y, lat, res, to);
      n_checks++;
      if (to || res !== {31'h0, v[i].f}) begin
        n_fail++; $display("FAIL early[%0d]: result=%h want %h timeout=%0d", i, res, {31'h0, v[i].f}, to);
      end
      n_checks++;
      if (lat !== v[i].lat) begin n_fail++; $display("FAIL early_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random();
    int lat, n, c, el; logic [31:0] res, x, y, m; logic [1:0] o; logic ef; bit to;
    for (int sel = 0; sel < 3; sel++) begin
      n = width_of(sel);
      c = chunk_of(sel);
      m = mask_of(n);
      for (int it = 0; it < 40; it++) begin
        o = 2'($urandom_range(0, 3));
        x = $urandom & m;
        case ($urandom_range(0, 3))
          0:       y = $urandom & m;
          1:       y = x;
          2:       y = (x ^ (32'h1 << $urandom_range(0, n - 1))) & m;
          default: y = (x ^ (mask_of(c) << (c * $urandom_range(0, n / c - 1)))) & m;
        endcase
        ef = model_flag(o, x, y, n);
        el = model_lat(x, y, n, c, early_of(sel));
        issue(sel, o, x, y, lat, res, to);
        n_checks++;
        if (to || res !== {31'h0, ef}) begin
          n_fail++; $display("FAIL random[%0d.%0d] op=%0d x=%h y=%h: result=%h want %h", sel, it, o, x, y, res, {31'h0, ef});
        end
        n_checks++;
        if (lat !== el) begin
          n_fail++; $display("FAIL random_lat[%0d.%0d] x=%h y=%h: got %0d want %0d", sel, it, x, y, lat, el);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res; bit to;
    out_ready = 1'b0;
    issue(0, 2'd1, 32'd5, 32'd9, lat, res, to);
    n_checks++;
    if (to || res !== 32'h1) begin n_fail++; $display("FAIL bp_first: result=%h want 1 timeout=%0d", res, to); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid[0] = 1'($urandom);
      op = 2'($urandom); X = $urandom; Y = $urandom;
      n_checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || res_a !== 32'h1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%h want 1/0/1", i, out_valid[0], in_ready[0], res_a);
      end
    end
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]);
    end
    issue(0, 2'd0, 32'hFFFF_FFFE, 32'd3, lat, res, to);
    n_checks++;
    if (to || res !== 32'h1 || lat !== 5) begin
      n_fail++; $display("FAIL bp_next: result=%h lat=%0d want 1/5", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    int w;
    @(negedge clk);
    op = 2'd1; X = 32'd1; Y = 32'd2;
    out_ready = 1'b1;
    in_valid[0] = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        rises.push_back(cyc);
        n_checks++;
        if (res_a !== 32'h1) begin n_fail++; $display("FAIL b2b_result@%0d: got %h want 1", cyc, res_a); end
      end
    end
    in_valid[0] = 1'b0;
    n_checks++;
    if (rises.size() < 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want >=2", rises.size());
    end else begin
      if (rises[0] !== 4 || rises[1] - rises[0] !== 6) begin
        n_fail++; $display("FAIL b2b_timing: first=%0d period=%0d want 4/6", rises[0], rises[1] - rises[0]);
      end
    end
    w = 0;
    while (busy[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; bit to;
    @(negedge clk);
    op = 2'd0; X = 32'hFFFF_FFFF; Y = 32'h1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid[0] !== 1'b0 || res_a !== 32'h0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: out_valid=%b result=%h busy=%b want 0/0/0", out_valid[0], res_a, busy[0]);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", in_ready[0]); end
    issue(0, 2'd1, 32'd3, 32'd5, lat, res, to);
    n_checks++;
    if (to || res !== 32'h1 || lat !== 5) begin
      n_fail++; $display("FAIL mid_reset_fresh: result=%h lat=%0d want 1/5", res, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_signed_compare();
    test_equality();
    test_early_exit();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
